md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//  Multiply/divide sequencer owning the HI/LO register pair for the 5-stage pipeline.
//  Accepts mult/div ops issued from the E stage and models a multi-cycle latency with a counter FSM.
//  Serves mthi/mtlo writes and mfhi/mflo reads.
//  Raises a D-stage stall request while the unit is busy and the D-stage instruction touches HI/LO.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (and madd/msub family); legal range 1..15
//  DIV_CYCLES   10  busy cycles for div/divu; legal range 1..15
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  md_start   in   1   E-stage holds a mult/div-family op this cycle
//  md_op      in   3   0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 msubu
//  rs_val     in   32  forwarded rs operand (E stage)
//  rt_val     in   32  forwarded rt operand (E stage)
//  hilo_we    in   1   E-stage mthi/mtlo write enable
//  hilo_sel   in   1   0 = LO, 1 = HI (for both write and read)
//  hilo_wdata in   32  mthi/mtlo data (rs_val after forwarding)
//  md_use_D   in   1   D-stage instruction is mult/div/mf*/mt*/madd family
//  hilo_rdata out  32  combinational HI or LO per hilo_sel (for mfhi/mflo in E)
//  busy       out  1   operation in flight
//  stall_req  out  1   md_use_D & (busy | md_start); ORed into the pipeline stop signal
// BEHAVIOUR
//  - Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0, FSM=IDLE.
//    Reset mid-operation aborts the op; HI/LO are cleared, not written.
//  - FSM states: IDLE, RUN. Counter is 4 bits.
//  - IDLE with md_start=1 and a legal op:
//    - Capture the op and the result into internal shadow regs.
//    - Load the counter with MULT_CYCLES or DIV_CYCLES; go to RUN. busy=1 from the next cycle.
//  - RUN: decrement the counter each cycle.
//    - At counter==1: commit the shadow result to HI/LO; go to IDLE. busy=0 on that same edge.
//    - busy is high for exactly N cycles after the start cycle.
//  - Results:
//    - mult: {HI,LO} = signed 64-bit product. multu: {HI,LO} = unsigned 64-bit product.
//    - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
//    - divu: unsigned quotient and remainder.
//  - Divide by zero: full DIV_CYCLES still elapse. HI/LO keep their previous values (no commit).
//  - md_start while busy: ignored (the pipeline must never do this because stall_req holds D).
//  - hilo_we:
//    - Writes the selected register at the clock edge when IDLE and md_start=0.
//    - Ignored while busy.
//    - If asserted together with md_start, md_start wins and the write is dropped.
//  - hilo_rdata reads the architectural HI/LO. It is never the in-flight shadow value.
//  - stall_req is combinational, with no registered latency. It includes md_start so a dependent
//    D-stage instruction behind an issuing op stalls in the issue cycle.
// CONFIGURATION
//  MD_MADD_EN defined:
//    - ops 4..7 are legal: madd/maddu: {HI,LO} += product; msub/msubu: {HI,LO} -= product.
//    - 64-bit add wraps; use MULT_CYCLES.
//    - The accumulate source is HI/LO at the start cycle.
//  MD_MADD_EN undefined: ops 4..7 are illegal. md_start with them is ignored (no busy, HI/LO unchanged).
// TESTING
//  1 mult rs=32'hFFFFFFFD (-3), rt=5: busy high 5 cycles -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1
//  2 div rs=-7, rt=2: busy high 10 cycles -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF
//    divu rs=7, rt=2 -> LO=3, HI=1
//  3 md_use_D=1 during each busy cycle and during the start cycle -> stall_req=1
//    md_use_D=0 -> stall_req=0; stall_req=0 on the first cycle after busy falls
//  4 mtlo 32'h1234 then div rs=5, rt=0 -> after 10 cycles LO=32'h1234, HI unchanged
//  5 reset pulled low at cycle 4 of a div -> busy=0, HI=LO=0 immediately (async)
//    no late commit after reset releases
//  6 MD_MADD_EN: HI=0, LO=32'hFFFFFFFF, maddu rs=1, rt=1 -> HI=1, LO=0
//    without MD_MADD_EN the same op -> busy stays 0, HI/LO unchanged

Source files
------------

// File: rtl/md_unit_ctrl.sv
//==============================================================================
// Module      : md_unit_ctrl
// Description : Multi-cycle multiply/divide sequencer owning the HI/LO pair.
//               Optional madd/msub family enabled by defining MD_MADD_EN.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    input  logic        md_use_D,
    output logic [31:0] hilo_rdata,
    output logic        busy,
    output logic        stall_req
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_shadow;
    logic        r_commit;

    logic        w_signed;
    logic        w_is_div;
    logic        w_legal;
    logic        w_div_zero;
    logic [63:0] w_rs_ext;
    logic [63:0] w_rt_ext;
    logic [63:0] w_prod;
    logic [31:0] w_abs_rs;
    logic [31:0] w_abs_rt;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_result;

    // Even opcodes are the signed variants of every pair.
    assign w_signed   = ~md_op[0];
    assign w_is_div   = (md_op == 3'd2) || (md_op == 3'd3);
    assign w_div_zero = (rt_val == 32'd0);

`ifdef MD_MADD_EN
    assign w_legal = 1'b1;
`else
    assign w_legal = ~md_op[2];
`endif

    always_comb begin
        w_rs_ext = {{32{w_signed & rs_val[31]}}, rs_val};
        w_rt_ext = {{32{w_signed & rt_val[31]}}, rt_val};
        // The low 64 bits of an extended product are exact for both signednesses.
        w_prod   = w_rs_ext * w_rt_ext;
    end

    // Divide on magnitudes and restore signs afterwards; this sidesteps the
    // INT_MIN / -1 overflow case and gives truncation toward zero.
    always_comb begin
        w_abs_rs  = (w_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
        w_abs_rt  = (w_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
        w_divisor = w_div_zero ? 32'd1 : w_abs_rt;
        w_q_mag   = w_abs_rs / w_divisor;
        w_r_mag   = w_abs_rs % w_divisor;
        w_quot    = (w_signed && (rs_val[31] ^ rt_val[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
        w_rem     = (w_signed && rs_val[31]) ? (~w_r_mag + 32'd1) : w_r_mag;
    end

    always_comb begin
        w_result = w_prod;
        if (w_is_div) begin
            w_result = {w_rem, w_quot};
        end
`ifdef MD_MADD_EN
        else if (md_op[2]) begin
            w_result = md_op[1] ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            busy     <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_shadow <= 64'd0;
            r_commit <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (md_start && w_legal) begin
                        r_state  <= RUN;
                        r_cnt    <= w_is_div ? C_DIV_CNT : C_MULT_CNT;
                        busy     <= 1'b1;
                        r_shadow <= w_result;
                        r_commit <= ~(w_is_div & w_div_zero);
                    end else if (!md_start && hilo_we) begin
                        if (hilo_sel) begin
                            r_hi <= hilo_wdata;
                        end else begin
                            r_lo <= hilo_wdata;
                        end
                    end
                end
                RUN: begin
                    if (r_cnt == 4'd1) begin
                        if (r_commit) begin
                            r_hi <= r_shadow[63:32];
                            r_lo <= r_shadow[31:0];
                        end
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign hilo_rdata = hilo_sel ? r_hi : r_lo;
    assign stall_req  = md_use_D & (busy | md_start);

endmodule

`default_nettype wire

// File: tb/tb_md_unit_ctrl.sv
//==============================================================================
// Module      : tb_md_unit_ctrl
// Description : Directed self-checking bench for md_unit_ctrl (default 5/10 cycles).
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_md_unit_ctrl;

    logic        clk;
    logic        reset;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] hilo_wdata;
    logic        md_use_D;
    logic [31:0] hilo_rdata;
    logic        busy;
    logic        stall_req;

    int n_assert = 0;
    int n_fail   = 0;

    md_unit_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .md_start   (md_start),
        .md_op      (md_op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .hilo_we    (hilo_we),
        .hilo_sel   (hilo_sel),
        .hilo_wdata (hilo_wdata),
        .md_use_D   (md_use_D),
        .hilo_rdata (hilo_rdata),
        .busy       (busy),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        hilo_sel = 1'b1;
        #1;
        chk({tag, "_hi"}, hilo_rdata, exp_hi);
        hilo_sel = 1'b0;
        #1;
        chk({tag, "_lo"}, hilo_rdata, exp_lo);
    endtask

    // Called one sample after the start edge; expects busy for exactly n samples.
    task automatic run_busy(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_stall%0d", tag, i), {31'd0, stall_req}, {31'd0, md_use_D});
            tick();
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        md_start   = 1'b0;
        md_op      = 3'd0;
        rs_val     = 32'd0;
        rt_val     = 32'd0;
        hilo_we    = 1'b0;
        hilo_sel   = 1'b0;
        hilo_wdata = 32'd0;
        md_use_D   = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk_hilo("rst", 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // mult -3 * 5, dependent D-stage instruction stalls throughout
        md_use_D = 1'b1;
        md_start = 1'b1;
        md_op    = 3'd0;
        rs_val   = 32'hFFFF_FFFD;
        rt_val   = 32'd5;
        #1;
        chk("mult_stall_issue", {31'd0, stall_req}, 32'd1);
        tick();
        md_start = 1'b0;
        hilo_sel = 1'b0;
        #1;
        chk("mult_lo_not_shadow", hilo_rdata, 32'd0);
        run_busy("mult", 5);
        chk("mult_stall_after", {31'd0, stall_req}, 32'd0);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // div -7 / 2 with no dependent D-stage instruction
        md_use_D = 1'b0;
        md_start = 1'b1;
        md_op    = 3'd2;
        rs_val   = 32'hFFFF_FFF9;
        rt_val   = 32'd2;
        #1;
        chk("div_stall_nouse", {31'd0, stall_req}, 32'd0);
        tick();
        md_start = 1'b0;
        run_busy("div", 10);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // divu 7 / 2
        md_start = 1'b1;
        md_op    = 3'd3;
        rs_val   = 32'd7;
        rt_val   = 32'd2;
        tick();
        md_start = 1'b0;
        run_busy("divu", 10);
        chk_hilo("divu", 32'd1, 32'd3);

        // mtlo, then divide by zero with a colliding write at start and writes while busy
        hilo_we    = 1'b1;
        hilo_sel   = 1'b0;
        hilo_wdata = 32'h0000_1234;
        tick();
        hilo_we = 1'b0;
        chk_hilo("mtlo", 32'd1, 32'h0000_1234);
        md_start   = 1'b1;
        md_op      = 3'd2;
        rs_val     = 32'd5;
        rt_val     = 32'd0;
        hilo_we    = 1'b1;
        hilo_sel   = 1'b1;
        hilo_wdata = 32'h0000_BEEF;
        tick();
        md_start   = 1'b0;
        hilo_wdata = 32'hAAAA_5555;
        run_busy("divz", 10);
        hilo_we = 1'b0;
        chk_hilo("divz", 32'd1, 32'h0000_1234);

        // asynchronous reset in the fourth busy cycle of a div
        md_start = 1'b1;
        md_op    = 3'd2;
        rs_val   = 32'd100;
        rt_val   = 32'd7;
        tick();
        md_start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk_hilo("abort", 32'd0, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
        end
        chk("abort_busy_late", {31'd0, busy}, 32'd0);
        chk_hilo("abort_late", 32'd0, 32'd0);

        // maddu with HI=0, LO=FFFFFFFF
        hilo_we    = 1'b1;
        hilo_sel   = 1'b0;
        hilo_wdata = 32'hFFFF_FFFF;
        tick();
        hilo_we  = 1'b0;
        md_start = 1'b1;
        md_op    = 3'd5;
        rs_val   = 32'd1;
        rt_val   = 32'd1;
        tick();
        md_start = 1'b0;
`ifdef MD_MADD_EN
        run_busy("maddu", 5);
        chk_hilo("maddu", 32'd1, 32'd0);
`else
        chk("maddu_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        tick();
        chk("maddu_busy_late", {31'd0, busy}, 32'd0);
        chk_hilo("maddu", 32'd0, 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
